// File: rtl/decim_avg_hg.sv
// Decimating boxcar averager.
// Sums PERIOD consecutive samples, then scales the sum by K ~= 2**(CNTW+15)/PERIOD
// with a 16-step serial shift-add multiply, rounds half-up and saturates.
// One averaged sample per window, flagged by a one-cycle strobe.
module decim_avg_hg #(
    parameter int PERIOD = 350,
    parameter int CNTW   = 9,
    parameter int K      = 47934,
    parameter int DW     = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] y_in,
    input  logic                 sync,
    input  logic                 clear_err,
    output logic signed [DW-1:0] y_out,
    output logic                 strobe_out,
    output logic [CNTW-1:0]      phase,
    output logic                 timing_error
);
    // Accumulator width holds PERIOD full-scale samples; the product register
    // has room for hold*K plus the rounding offset without overflow.
    localparam int AW = DW + CNTW;
    localparam int PW = AW + 17;
    localparam int SH = CNTW + 15;

    localparam logic [15:0]             KB   = 16'(K);
    localparam logic [CNTW-1:0]         LAST = CNTW'(PERIOD - 1);
    localparam logic signed [PW-1:0]    RND  = PW'(1) <<< (SH - 1);
    localparam logic signed [PW-1:0]    MAXV = (PW'(1) <<< (DW - 1)) - PW'(1);
    localparam logic signed [PW-1:0]    MINV = -(PW'(1) <<< (DW - 1));

    generate
        if (PERIOD < 18 || PERIOD > (1 << CNTW)) begin : g_period_chk
            $error("decim_avg_hg: PERIOD must be in [18, 2**CNTW]");
        end
        if (K < 0 || K > 65535) begin : g_k_chk
            $error("decim_avg_hg: K must fit in 16 unsigned bits");
        end
    endgenerate

    logic [CNTW-1:0]        cnt;
    logic [CNTW-1:0]        ph;
    logic                   dump;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   sum;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   mcand;
    logic signed [PW-1:0]   rnd_sum;
    logic signed [PW-1:0]   shr;
    logic signed [PW-1:0]   sat;
    logic [3:0]             mbit;
    logic                   busy;
    logic                   fin;

    assign phase = cnt;

    // Effective phase of this cycle's sample; sync restarts the window here.
    always_comb begin
        ph   = sync ? '0 : cnt;
        dump = !sync && (cnt == LAST);
        sum  = acc + AW'(y_in);
    end

    // Phase counter, accumulator and sticky timing error (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            acc          <= '0;
            timing_error <= 1'b0;
        end else begin
            cnt <= (ph == LAST) ? '0 : ph + CNTW'(1);
            acc <= (ph == '0) ? AW'(y_in) : sum;
            if (sync && cnt != '0)
                timing_error <= 1'b1;
            else if (clear_err)
                timing_error <= 1'b0;
        end
    end

    // Serial multiply, LSB of K first. Bit 0 is folded into the dump cycle so
    // the 16 steps end in time for the round stage to strobe 17 cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            mcand <= '0;
            mbit  <= '0;
            busy  <= 1'b0;
            fin   <= 1'b0;
        end else begin
            fin <= 1'b0;
            if (dump) begin
                prod  <= KB[0] ? PW'(sum) : '0;
                mcand <= PW'(sum) <<< 1;
                mbit  <= 4'd1;
                busy  <= 1'b1;
            end else if (busy) begin
                if (KB[mbit])
                    prod <= prod + mcand;
                mcand <= mcand <<< 1;
                mbit  <= mbit + 4'd1;
                if (mbit == 4'd15) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end
            end
        end
    end

    // Round half-up via offset plus arithmetic shift, then clamp to DW bits.
    always_comb begin
        rnd_sum = prod + RND;
        shr     = rnd_sum >>> SH;
        sat     = shr;
        if (shr > MAXV)
            sat = MAXV;
        else if (shr < MINV)
            sat = MINV;
    end

    // Output register: value and strobe change together, value held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out      <= '0;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= fin;
            if (fin)
                y_out <= DW'(sat);
        end
    end

endmodule

// File: tb/tb_decim_avg_hg.sv
// Bench for decim_avg_hg: randomized and directed streams against a window-sum model.
module tb_decim_avg_hg;
    localparam int PERIOD = 350;
    localparam int CNTW   = 9;
    localparam int K      = 47934;
    localparam int DW     = 18;
    localparam int LAT    = 17;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] y_in;
    logic                 sync;
    logic                 clear_err;
    logic signed [DW-1:0] y_out;
    logic                 strobe_out;
    logic [CNTW-1:0]      phase;
    logic                 timing_error;

    decim_avg_hg #(.PERIOD(PERIOD), .CNTW(CNTW), .K(K), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .sync(sync), .clear_err(clear_err),
        .y_out(y_out), .strobe_out(strobe_out), .phase(phase), .timing_error(timing_error)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state: window phase, running sum, scheduled outputs.
    int                   cyc;
    int                   mph;
    longint               msum;
    int                   pend_due[$];
    longint               pend_val[$];
    logic                 e_str;
    logic signed [DW-1:0] e_y;
    logic                 e_err;

    function automatic longint avg(input longint s);
        longint r;
        longint hi;
        hi = (64'sd1 <<< (DW - 1)) - 1;
        r = (s * K + (64'sd1 <<< (CNTW + 14))) >>> (CNTW + 15);
        if (r > hi) r = hi;
        if (r < -hi - 1) r = -hi - 1;
        return r;
    endfunction

    // Drive one sample and advance the model; returns at the next falling edge.
    task automatic tick(input int y, input bit s, input bit c);
        int ph;
        y_in = DW'(y); sync = s; clear_err = c;
        cyc++;
        e_str = 1'b0;
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            e_y = DW'(pend_val[0]);
            e_str = 1'b1;
            void'(pend_due.pop_front());
            void'(pend_val.pop_front());
        end
        ph = s ? 0 : mph;
        if (s && mph != 0) e_err = 1'b1;
        else if (c) e_err = 1'b0;
        msum = (ph == 0) ? longint'(y) : msum + y;
        if (ph == PERIOD - 1) begin
            pend_due.push_back(cyc + LAT - 1);
            pend_val.push_back(avg(msum));
        end
        mph = (ph == PERIOD - 1) ? 0 : ph + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rst_on();
        rst_n = 1'b0; sync = 1'b0; clear_err = 1'b0; y_in = '0;
        #1;
    endtask

    task automatic rst_off();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; mph = 0; msum = 0;
        pend_due.delete(); pend_val.delete();
        e_str = 1'b0; e_y = '0; e_err = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_on();
        ncmp++;
        if ({strobe_out, y_out, phase, timing_error} !== {1'b0, {DW{1'b0}}, {CNTW{1'b0}}, 1'b0}) begin
            nerr++;
            $display("FAIL reset_async got s=%b y=%0d ph=%0d e=%b want all zero", strobe_out, y_out, phase, timing_error);
        end
        rst_off();
        ncmp++;
        if (phase !== '0) begin
            nerr++;
            $display("FAIL reset_phase0 got ph=%0d want 0", phase);
        end
        tick(5, 0, 0);
        ncmp++;
        if (phase !== CNTW'(1)) begin
            nerr++;
            $display("FAIL reset_phase1 got ph=%0d want 1", phase);
        end
    endtask

    // Constant input: checks value, first-strobe latency and strobe period.
    task automatic test_const(input int val);
        int first = -1;
        int second = -1;
        rst_on(); rst_off();
        for (int i = 0; i < 2 * PERIOD + LAT + 3; i++) begin
            tick(val, 0, 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL const(%0d) cyc=%0d got s=%b y=%0d ph=%0d e=%b want s=%b y=%0d ph=%0d e=%b",
                         val, cyc, strobe_out, y_out, phase, timing_error, e_str, e_y, mph, e_err);
            end
            if (strobe_out === 1'b1) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        ncmp++;
        if (first != PERIOD - 1 + LAT) begin
            nerr++;
            $display("FAIL const_first_strobe got cyc=%0d want %0d", first, PERIOD - 1 + LAT);
        end
        ncmp++;
        if (second - first != PERIOD) begin
            nerr++;
            $display("FAIL const_strobe_period got %0d want %0d", second - first, PERIOD);
        end
        ncmp++;
        if (y_out !== DW'(val)) begin
            nerr++;
            $display("FAIL const_value got %0d want %0d", y_out, val);
        end
    endtask

    task automatic test_ramp();
        int seen = 0;
        rst_on(); rst_off();
        for (int i = 0; i < PERIOD + LAT + 2; i++) begin
            tick(mph, 0, 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL ramp cyc=%0d got s=%b y=%0d ph=%0d want s=%b y=%0d ph=%0d",
                         cyc, strobe_out, y_out, phase, e_str, e_y, mph);
            end
            if (strobe_out === 1'b1) seen++;
        end
        ncmp++;
        if (seen != 1 || y_out !== 18'sd174) begin
            nerr++;
            $display("FAIL ramp_value got strobes=%0d y=%0d want 1 strobe y=174", seen, y_out);
        end
    endtask

    // Full-scale inputs: model value, plus sign must survive (no wrap).
    task automatic test_extremes(input int val);
        rst_on(); rst_off();
        for (int i = 0; i < PERIOD + LAT + 2; i++) begin
            tick(val, 0, 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL extreme(%0d) cyc=%0d got s=%b y=%0d want s=%b y=%0d",
                         val, cyc, strobe_out, y_out, e_str, e_y);
            end
        end
        ncmp++;
        if ((val < 0) != (y_out < 0) || y_out == 0) begin
            nerr++;
            $display("FAIL extreme_sign got %0d for input %0d", y_out, val);
        end
    endtask

    // Misaligned, aligned and last-phase sync, plus clear_err.
    task automatic test_sync();
        int s_cyc = 0;
        int first = -1;
        rst_on(); rst_off();
        while (mph != 100) tick(500, 0, 0);
        tick(500, 1, 0);
        s_cyc = cyc - 1;
        ncmp++;
        if (timing_error !== 1'b1) begin
            nerr++;
            $display("FAIL sync_err_set got %b want 1", timing_error);
        end
        for (int i = 0; i < PERIOD + LAT + 2; i++) begin
            tick(500, 0, 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL sync_mid cyc=%0d got s=%b y=%0d ph=%0d e=%b want s=%b y=%0d ph=%0d e=%b",
                         cyc, strobe_out, y_out, phase, timing_error, e_str, e_y, mph, e_err);
            end
            if (strobe_out === 1'b1 && first < 0) first = cyc;
        end
        ncmp++;
        if (first - s_cyc != PERIOD - 1 + LAT || y_out !== 18'sd500) begin
            nerr++;
            $display("FAIL sync_restart got delay=%0d y=%0d want %0d y=500", first - s_cyc, y_out, PERIOD - 1 + LAT);
        end
        tick(500, 0, 1);
        ncmp++;
        if (timing_error !== 1'b0) begin
            nerr++;
            $display("FAIL clear_err got %b want 0", timing_error);
        end
        while (mph != 0) tick(500, 0, 0);
        tick(500, 1, 0);
        ncmp++;
        if (timing_error !== 1'b0) begin
            nerr++;
            $display("FAIL sync_phase0 got err=%b want 0", timing_error);
        end
        while (mph != PERIOD - 1) tick(500, 0, 0);
        tick(500, 1, 1);
        ncmp++;
        if (timing_error !== 1'b1) begin
            nerr++;
            $display("FAIL sync_last_set_wins got err=%b want 1", timing_error);
        end
        for (int i = 0; i < LAT + 4; i++) begin
            tick(500, 0, 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL sync_last cyc=%0d got s=%b y=%0d ph=%0d want s=%b y=%0d ph=%0d",
                         cyc, strobe_out, y_out, phase, e_str, e_y, mph);
            end
        end
    endtask

    task automatic test_random();
        int y;
        rst_on(); rst_off();
        for (int i = 0; i < 4 * PERIOD; i++) begin
            y = int'($urandom_range(0, 262143)) - 131072;
            if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 2000)) - 1000;
            tick(y, $urandom_range(0, 399) == 0, $urandom_range(0, 49) == 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL random cyc=%0d got s=%b y=%0d ph=%0d e=%b want s=%b y=%0d ph=%0d e=%b",
                         cyc, strobe_out, y_out, phase, timing_error, e_str, e_y, mph, e_err);
            end
        end
    endtask

    // Reset 5 cycles after a dump: no stale strobe, fresh window after release.
    task automatic test_reset_mid();
        int first = -1;
        rst_on(); rst_off();
        for (int i = 0; i < PERIOD + 5; i++) tick(700, 0, 0);
        rst_on();
        ncmp++;
        if ({strobe_out, y_out, phase, timing_error} !== {1'b0, {DW{1'b0}}, {CNTW{1'b0}}, 1'b0}) begin
            nerr++;
            $display("FAIL reset_mid_async got s=%b y=%0d ph=%0d e=%b want all zero", strobe_out, y_out, phase, timing_error);
        end
        rst_off();
        for (int i = 0; i < PERIOD + LAT + 2; i++) begin
            tick(-300, 0, 0);
            ncmp++;
            if ({strobe_out, y_out, phase, timing_error} !== {e_str, e_y, CNTW'(mph), e_err}) begin
                nerr++;
                $display("FAIL reset_mid cyc=%0d got s=%b y=%0d ph=%0d want s=%b y=%0d ph=%0d",
                         cyc, strobe_out, y_out, phase, e_str, e_y, mph);
            end
            if (strobe_out === 1'b1 && first < 0) first = cyc;
        end
        ncmp++;
        if (first != PERIOD - 1 + LAT || y_out !== -18'sd300) begin
            nerr++;
            $display("FAIL reset_mid_restart got cyc=%0d y=%0d want %0d y=-300", first, y_out, PERIOD - 1 + LAT);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b1; y_in = '0; sync = 1'b0; clear_err = 1'b0;
        cyc = 0; mph = 0; msum = 0; e_str = 1'b0; e_y = '0; e_err = 1'b0;
        test_reset();
        test_const(1000);
        test_const(-1000);
        test_ramp();
        test_extremes(131071);
        test_extremes(-131072);
        test_sync();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
